// File: rtl/pll_lock_reset_gen.sv
// PLL lock qualifier: holds the system reset until PLL lock has been stable, and re-asserts it on lock loss.
// The lock-loss event counter is built only when PLL_LOCK_RST_LOSS_COUNT_EN is defined.
module pll_lock_reset_gen #(
   parameter int STABLE_CYCLES  = 1024,
   parameter int MIN_RST_CYCLES = 16,
   parameter int CNT_W          = 16,
   parameter int LOSS_W         = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              pll_lock,
   output logic              sys_rst_n,
   output logic              ready,
   output logic              lost_pulse,
   output logic [LOSS_W-1:0] loss_cnt
);

   typedef enum logic [1:0] {
      WAIT,
      SETTLE,
      RUN,
      HOLD
   } state_t;

   localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(MIN_RST_CYCLES - 1);

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             lock_m;
   logic             lock_s;

   // bring the asynchronous lock flag into the clk domain
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lock_m <= 1'b0;
         lock_s <= 1'b0;
      end else begin
         lock_m <= pll_lock;
         lock_s <= lock_m;
      end
   end

   // sequencing FSM; all outputs are registered alongside the state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= WAIT;
         cnt        <= '0;
         sys_rst_n  <= 1'b0;
         ready      <= 1'b0;
         lost_pulse <= 1'b0;
      end else begin
         lost_pulse <= 1'b0;
         unique case (state)
            WAIT: begin
               if (lock_s) begin
                  state <= SETTLE;
                  cnt   <= '0;
               end
            end
            SETTLE: begin
               if (!lock_s) begin
                  state <= WAIT;
                  cnt   <= '0;
               end else if (cnt == STABLE_LAST) begin
                  state     <= RUN;
                  cnt       <= '0;
                  sys_rst_n <= 1'b1;
                  ready     <= 1'b1;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            RUN: begin
               if (!lock_s) begin
                  state      <= HOLD;
                  cnt        <= '0;
                  sys_rst_n  <= 1'b0;
                  ready      <= 1'b0;
                  lost_pulse <= 1'b1;
               end
            end
            HOLD: begin
               if (cnt == HOLD_LAST) begin
                  state <= WAIT;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            default: begin
               state <= WAIT;
               cnt   <= '0;
            end
         endcase
      end
   end

`ifdef PLL_LOCK_RST_LOSS_COUNT_EN
   // saturating count of lock losses, updated on the same edge as lost_pulse
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         loss_cnt <= '0;
      end else if (state == RUN && !lock_s && loss_cnt != '1) begin
         loss_cnt <= loss_cnt + LOSS_W'(1);
      end
   end
`else
   assign loss_cnt = '0;
`endif

endmodule

// File: tb/tb_pll_lock_reset_gen.sv
// Bench for pll_lock_reset_gen: directed scenarios plus random lock patterns
// compared cycle by cycle against a streak/timer reference model.
module tb_pll_lock_reset_gen;

   localparam int STABLE = 8;
   localparam int MINR   = 4;
   localparam int LW     = 2;
   localparam int LMAX   = (1 << LW) - 1;

   logic          clk;
   logic          rst_n;
   logic          pll_lock;
   logic          sys_rst_n;
   logic          ready;
   logic          lost_pulse;
   logic [LW-1:0] loss_cnt;

   int tests;
   int fails;

   pll_lock_reset_gen #(
      .STABLE_CYCLES (STABLE),
      .MIN_RST_CYCLES(MINR),
      .CNT_W         (16),
      .LOSS_W        (LW)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .pll_lock  (pll_lock),
      .sys_rst_n (sys_rst_n),
      .ready     (ready),
      .lost_pulse(lost_pulse),
      .loss_cnt  (loss_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // reference model: lock seen two edges late; release after an unbroken
   // streak of STABLE+1 seen-high edges; a loss starts a MINR-edge hold timer
   logic          d1, d2, seen;
   logic          m_rst, m_rdy, m_pls;
   logic [LW-1:0] m_loss;
   int            mode;
   int            streak;
   int            hold_left;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         d1 = 0; d2 = 0; mode = 0; streak = 0; hold_left = 0;
         m_rst = 0; m_rdy = 0; m_pls = 0; m_loss = '0;
      end else begin
         seen  = d2;
         d2    = d1;
         d1    = pll_lock;
         m_pls = 0;
         if (mode == 1) begin
            if (!seen) begin
               mode      = 2;
               hold_left = MINR;
               m_pls     = 1;
`ifdef PLL_LOCK_RST_LOSS_COUNT_EN
               if (int'(m_loss) < LMAX) m_loss = m_loss + 1'b1;
`endif
            end
         end else if (mode == 2) begin
            hold_left--;
            if (hold_left == 0) begin
               mode   = 0;
               streak = 0;
            end
         end else begin
            streak = seen ? streak + 1 : 0;
            if (streak == STABLE + 1) mode = 1;
         end
         m_rst = (mode == 1);
         m_rdy = m_rst;
      end
   end

   task automatic test_reset();
      int rise;
      rise     = 0;
      rst_n    = 1'b0;
      pll_lock = 1'b1;
      repeat (3) @(negedge clk);
      tests++;
      if ({sys_rst_n, ready, lost_pulse, loss_cnt} !== 5'b0) begin
         fails++;
         $display("FAIL reset_state got %b exp 00000",
                  {sys_rst_n, ready, lost_pulse, loss_cnt});
      end
      rst_n = 1'b1;
      for (int k = 1; k <= 30; k++) begin
         @(negedge clk);
         tests++;
         if ({sys_rst_n, ready, lost_pulse, loss_cnt} !==
             {m_rst, m_rdy, m_pls, m_loss}) begin
            fails++;
            $display("FAIL reset_model k=%0d got %b exp %b", k,
                     {sys_rst_n, ready, lost_pulse, loss_cnt},
                     {m_rst, m_rdy, m_pls, m_loss});
         end
         if (sys_rst_n === 1'b1 && rise == 0) rise = k;
      end
      tests++;
      if (rise != STABLE + 3) begin
         fails++;
         $display("FAIL reset_release_edge got %0d exp %0d", rise, STABLE + 3);
      end
   endtask

   task automatic test_settle_abort();
      int rise;
      int pulses;
      rise     = 0;
      pulses   = 0;
      rst_n    = 1'b0;
      pll_lock = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 38; i++) begin
         if (i == 0) pll_lock = 1'b1;
         if (i == 5) pll_lock = 1'b0;
         if (i == 8) pll_lock = 1'b1;
         @(negedge clk);
         tests++;
         if ({sys_rst_n, ready, lost_pulse, loss_cnt} !==
             {m_rst, m_rdy, m_pls, m_loss}) begin
            fails++;
            $display("FAIL settle_model i=%0d got %b exp %b", i,
                     {sys_rst_n, ready, lost_pulse, loss_cnt},
                     {m_rst, m_rdy, m_pls, m_loss});
         end
         if (lost_pulse === 1'b1) pulses++;
         if (sys_rst_n === 1'b1 && rise == 0) rise = i - 7;
      end
      tests++;
      if (rise != STABLE + 3) begin
         fails++;
         $display("FAIL settle_release_edge got %0d exp %0d", rise, STABLE + 3);
      end
      tests++;
      if (pulses != 0) begin
         fails++;
         $display("FAIL settle_no_pulse got %0d exp 0", pulses);
      end
   endtask

   task automatic test_loss();
      int fall, rise, pulses, pulse_k;
      fall = 0; rise = 0; pulses = 0; pulse_k = 0;
      tests++;
      if (ready !== 1'b1) begin
         fails++;
         $display("FAIL loss_precond_ready got %b exp 1", ready);
      end
      pll_lock = 1'b0;
      for (int k = 1; k <= 30; k++) begin
         @(negedge clk);
         if (k == 1) pll_lock = 1'b1;
         tests++;
         if ({sys_rst_n, ready, lost_pulse, loss_cnt} !==
             {m_rst, m_rdy, m_pls, m_loss}) begin
            fails++;
            $display("FAIL loss_model k=%0d got %b exp %b", k,
                     {sys_rst_n, ready, lost_pulse, loss_cnt},
                     {m_rst, m_rdy, m_pls, m_loss});
         end
         if (lost_pulse === 1'b1) begin
            pulses++;
            pulse_k = k;
         end
         if (sys_rst_n === 1'b0 && fall == 0) fall = k;
         if (fall != 0 && sys_rst_n === 1'b1 && rise == 0) rise = k;
      end
      tests++;
      if (fall != 3) begin
         fails++;
         $display("FAIL loss_fall_edge got %0d exp 3", fall);
      end
      tests++;
      if (pulses != 1 || pulse_k != 3) begin
         fails++;
         $display("FAIL loss_pulse got n=%0d at %0d exp n=1 at 3", pulses, pulse_k);
      end
      tests++;
      if (rise != 3 + MINR + 1 + STABLE) begin
         fails++;
         $display("FAIL loss_rerelease_edge got %0d exp %0d", rise,
                  3 + MINR + 1 + STABLE);
      end
   endtask

   task automatic test_async_reset();
      int rise;
      rise     = 0;
      rst_n    = 1'b0;
      pll_lock = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (8) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      tests++;
      if ({sys_rst_n, ready, lost_pulse, loss_cnt} !== 5'b0) begin
         fails++;
         $display("FAIL async_settle got %b exp 00000",
                  {sys_rst_n, ready, lost_pulse, loss_cnt});
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         tests++;
         if ({sys_rst_n, ready, lost_pulse, loss_cnt} !==
             {m_rst, m_rdy, m_pls, m_loss}) begin
            fails++;
            $display("FAIL async_model k=%0d got %b exp %b", k,
                     {sys_rst_n, ready, lost_pulse, loss_cnt},
                     {m_rst, m_rdy, m_pls, m_loss});
         end
         if (sys_rst_n === 1'b1 && rise == 0) rise = k;
      end
      tests++;
      if (rise != STABLE + 3) begin
         fails++;
         $display("FAIL async_release_edge got %0d exp %0d", rise, STABLE + 3);
      end
      #2 rst_n = 1'b0;
      #1;
      tests++;
      if ({sys_rst_n, ready} !== 2'b00) begin
         fails++;
         $display("FAIL async_run got %b exp 00", {sys_rst_n, ready});
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_loss_count();
      int exp_cnt[5];
`ifdef PLL_LOCK_RST_LOSS_COUNT_EN
      exp_cnt = '{1, 2, 3, 3, 3};
`else
      exp_cnt = '{0, 0, 0, 0, 0};
`endif
      rst_n    = 1'b0;
      pll_lock = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (12) @(negedge clk);
      for (int ev = 0; ev < 5; ev++) begin
         pll_lock = 1'b0;
         repeat (2) @(negedge clk);
         pll_lock = 1'b1;
         for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            tests++;
            if ({sys_rst_n, ready, lost_pulse, loss_cnt} !==
                {m_rst, m_rdy, m_pls, m_loss}) begin
               fails++;
               $display("FAIL count_model ev=%0d got %b exp %b", ev,
                        {sys_rst_n, ready, lost_pulse, loss_cnt},
                        {m_rst, m_rdy, m_pls, m_loss});
            end
         end
         tests++;
         if (int'(loss_cnt) != exp_cnt[ev] || ready !== 1'b1) begin
            fails++;
            $display("FAIL loss_count ev=%0d got %0d rdy=%b exp %0d rdy=1",
                     ev + 1, loss_cnt, ready, exp_cnt[ev]);
         end
      end
   endtask

   task automatic test_toggle();
      int bad;
      bad      = 0;
      rst_n    = 1'b0;
      pll_lock = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 100; c++) begin
         if (c % 3 == 0) pll_lock = ~pll_lock;
         @(negedge clk);
         tests++;
         if ({sys_rst_n, ready, lost_pulse, loss_cnt} !==
             {m_rst, m_rdy, m_pls, m_loss}) begin
            fails++;
            $display("FAIL toggle_model c=%0d got %b exp %b", c,
                     {sys_rst_n, ready, lost_pulse, loss_cnt},
                     {m_rst, m_rdy, m_pls, m_loss});
         end
         if (sys_rst_n !== 1'b0 || ready !== 1'b0) bad++;
      end
      tests++;
      if (bad != 0) begin
         fails++;
         $display("FAIL toggle_no_release got %0d released cycles exp 0", bad);
      end
   endtask

   task automatic test_random();
      int seg;
      seg = 0;
      for (int c = 0; c < 1500; c++) begin
         if (seg == 0) begin
            pll_lock = ~pll_lock;
            seg = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 6)
                                              : $urandom_range(10, 30);
         end
         seg--;
         if ($urandom_range(0, 299) == 0) begin
            #2 rst_n = 1'b0;
            #2 rst_n = 1'b1;
         end
         @(negedge clk);
         tests++;
         if ({sys_rst_n, ready, lost_pulse, loss_cnt} !==
             {m_rst, m_rdy, m_pls, m_loss}) begin
            fails++;
            $display("FAIL random_model c=%0d got %b exp %b", c,
                     {sys_rst_n, ready, lost_pulse, loss_cnt},
                     {m_rst, m_rdy, m_pls, m_loss});
         end
      end
   endtask

   initial begin
      tests    = 0;
      fails    = 0;
      rst_n    = 1'b0;
      pll_lock = 1'b0;
      test_reset();
      test_settle_abort();
      test_loss();
      test_async_reset();
      test_loss_count();
      test_toggle();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
